// File: rtl/bridge_traffic_scheduler.sv
// Drawbridge scheduler: sequences road lights, deck drain, lift, boat passage.
// Ports: Clk, Reset (async low), car/boat/bridge sensors in; LiftReq, lights, CarCount, SchedState, Fault out.
module bridge_traffic_scheduler #(
    parameter int CNT_W      = 4,
    parameter int MIN_ROAD   = 16,
    parameter int YELLOW_CYC = 4,
    parameter int MAX_BOAT   = 32,
    parameter int MOVE_TO    = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CarIn,
    input  logic             CarOut,
    input  logic             CarWait,
    input  logic             BoatReq,
    input  logic             BridgeHigh,
    input  logic             BridgeFlat,
    input  logic             BridgeAlarm,
    output logic             LiftReq,
    output logic [1:0]       RoadLight,
    output logic             BoatLight,
    output logic [CNT_W-1:0] CarCount,
    output logic [2:0]       SchedState,
    output logic             Fault
);

    localparam int TW = $clog2(MOVE_TO + MIN_ROAD + MAX_BOAT + YELLOW_CYC + 1);

    localparam logic [2:0] S_GREEN  = 3'd0;
    localparam logic [2:0] S_YELLOW = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_RAISE  = 3'd3;
    localparam logic [2:0] S_BOAT   = 3'd4;
    localparam logic [2:0] S_LOWER  = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0]    TMR_MAX = '1;

    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt_n;
    logic             in_fault;
    logic [1:0]       light_n;
    logic             lift_n;

    // Code 7 is unreachable but treated exactly like FAULT.
    assign in_fault   = (state == S_FAULT) || (state == 3'd7);
    assign SchedState = state;

    // Deck counter: simultaneous in/out cancels; frozen once faulted.
    always_comb begin
        cnt_n = CarCount;
        if (!in_fault) begin
            if (CarIn && !CarOut && CarCount != CNT_MAX)
                cnt_n = CarCount + 1'b1;
            else if (CarOut && !CarIn && CarCount != '0)
                cnt_n = CarCount - 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_GREEN:
                if (BoatReq && timer >= TW'(MIN_ROAD))
                    state_n = S_YELLOW;
            S_YELLOW:
                if (timer == TW'(YELLOW_CYC - 1))
                    state_n = S_DRAIN;
            // Uses the post-update count so the last car leaving
            // releases the lift on the same edge.
            S_DRAIN:
                if (cnt_n == '0)
                    state_n = S_RAISE;
            S_RAISE:
                if (BridgeHigh)
                    state_n = S_BOAT;
                else if (timer >= TW'(MOVE_TO))
                    state_n = S_FAULT;
            S_BOAT:
                if (!BoatReq || (CarWait && timer >= TW'(MAX_BOAT)))
                    state_n = S_LOWER;
            S_LOWER:
                if (BridgeFlat)
                    state_n = S_GREEN;
                else if (timer >= TW'(MOVE_TO))
                    state_n = S_FAULT;
            default:
                state_n = S_FAULT;
        endcase
        // Contradictory sensors or an external alarm override everything.
        if (BridgeAlarm || (BridgeHigh && BridgeFlat))
            state_n = S_FAULT;
    end

    always_comb begin
        light_n = 2'b10;
        lift_n  = 1'b0;
        unique case (1'b1)
            (state_n == S_GREEN):  light_n = 2'b00;
            (state_n == S_YELLOW): light_n = 2'b01;
            (state_n == S_RAISE),
            (state_n == S_BOAT):   lift_n  = 1'b1;
            // FAULT keeps the lift command where it was.
            (state_n == S_FAULT),
            (state_n == 3'd7):     lift_n  = LiftReq;
            default:               lift_n  = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_GREEN;
            timer     <= '0;
            CarCount  <= '0;
            LiftReq   <= 1'b0;
            RoadLight <= 2'b00;
            BoatLight <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            state     <= state_n;
            CarCount  <= cnt_n;
            LiftReq   <= lift_n;
            RoadLight <= light_n;
            BoatLight <= (state_n == S_BOAT);
            Fault     <= Fault | (state_n == S_FAULT);
            if (state_n != state)
                timer <= '0;
            else if (timer != TMR_MAX)
                timer <= timer + 1'b1;
        end
    end

endmodule
